// File: rtl/spi_ram_slave.sv
// spi_ram_slave: SPI slave with an integrated single-port RAM.
//
// Each frame (SS_n low) carries a 2-bit opcode, then a payload:
//   00 SET_WADDR : ADDR_W address bits -> wr_addr, then ignore until SS_n rises
//   01 WRITE     : DATA_W-bit words, burst, each committed to mem[wr_addr++]
//   10 SET_RADDR : ADDR_W address bits -> rd_addr, then ignore until SS_n rises
//   11 READ      : gap-free burst of mem[rd_addr++] on MISO, MSB first
// Pointers persist across frames and wrap modulo 2**ADDR_W. The RAM (mem) is
// not cleared by reset.
//
// Ports:
//   clk   : block clock (the SPI bit clock), rising-edge sampling
//   rst_n : synchronous active-low reset
//   SS_n  : slave select, active low
//   MOSI  : serial data in, MSB first
//   MISO  : serial data out, MSB first, registered; 0 outside READ payload
//
// Handshake: there is no valid/ready pair here. Every rising edge with SS_n=0
// consumes exactly one MOSI bit (or produces one MISO bit in READ); SS_n=1 on
// any edge aborts the frame and discards any partial word or address.
module spi_ram_slave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int SR_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SR_W);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WADDR,
    WDATA,
    RADDR,
    RDATA,
    HOLD
  } state_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              miso_q, miso_d;

  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;
  logic [SR_W-1:0]   sr_shift;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    miso_d    = 1'b0;
    mem_we    = 1'b0;
    sr_shift  = {sr_q[SR_W-2:0], MOSI};
    mem_wdata = sr_shift[DATA_W-1:0];
    rd_word   = mem[rd_addr_q];

    if (SS_n) begin
      // Abort or idle: anything partially shifted is thrown away.
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // MOSI on the select edge carries no information.
          state_d = CMD;
          cnt_d   = '0;
          sr_d    = '0;
        end
        CMD: begin
          if (cnt_q == '0) begin
            sr_d  = sr_shift;
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = '0;
            sr_d  = '0;
            case ({sr_q[0], MOSI})
              2'b00:   state_d = WADDR;
              2'b01:   state_d = WDATA;
              2'b10:   state_d = RADDR;
              default: state_d = RDATA;
            endcase
          end
        end
        WADDR, RADDR: begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == ADDR_LAST) begin
            if (state_q == WADDR) wr_addr_d = sr_shift[ADDR_W-1:0];
            else                  rd_addr_d = sr_shift[ADDR_W-1:0];
            state_d = HOLD;
            cnt_d   = '0;
            sr_d    = '0;
          end
        end
        WDATA: begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == DATA_LAST) begin
            // Shift register is cleared per word, so the low DATA_W bits are the word.
            mem_we    = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            cnt_d     = '0;
            sr_d      = '0;
          end
        end
        RDATA: begin
          if (cnt_q == '0) begin
            // Load edge: MSB goes straight out, remaining bits wait in sr.
            sr_d               = '0;
            sr_d[DATA_W-1:0]   = {rd_word[DATA_W-2:0], 1'b0};
            miso_d             = rd_word[DATA_W-1];
            rd_addr_d          = rd_addr_q + ADDR_W'(1);
          end else begin
            miso_d = sr_q[DATA_W-1];
            sr_d   = sr_q << 1;
          end
          // The edge that emits the LSB rolls the counter to 0 so the next
          // edge reloads without a gap.
          if (cnt_q == DATA_LAST) cnt_d = '0;
          else                    cnt_d = cnt_q + CNT_W'(1);
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      miso_q    <= miso_d;
    end
  end

  // RAM has no reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[wr_addr_q] <= mem_wdata;
  end

  assign MISO = miso_q;

endmodule

// File: tb/tb_spi_ram_slave.sv
// Directed bench for spi_ram_slave: a default 8/8 instance (dut_a) driven by a
// table of whole frames plus hand-written multi-cycle sequences, and a 10/16
// instance (dut_b) for the wide-parameter wrap case.
module tb_spi_ram_slave;

  logic clk;
  logic rst_n;
  logic ss_a, ss_b;
  logic mosi_i;
  logic miso_a, miso_b;

  int tests;
  int fails;
  int cur_sel;

  spi_ram_slave #(.ADDR_W(8), .DATA_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi_i), .MISO(miso_a)
  );

  spi_ram_slave #(.ADDR_W(10), .DATA_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi_i), .MISO(miso_b)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] data;
    int          nbits;
    logic [63:0] exp_rx;
    logic [7:0]  exp_wr;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[9];

  // Scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_miso();
    return (cur_sel == 0) ? miso_a : miso_b;
  endfunction

  // Driver tasks: inputs change just after a negedge, the DUT samples on the
  // posedge, and outputs are read at the following negedge.
  task automatic drive(input logic ss, input logic mosi);
    if (cur_sel == 0) begin ss_a = ss; ss_b = 1'b1; end
    else              begin ss_b = ss; ss_a = 1'b1; end
    mosi_i = mosi;
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [1:0] op);
    drive(1'b0, 1'b0);   // k0
    drive(1'b0, op[1]);  // k1
    drive(1'b0, op[0]);  // k2
  endtask

  task automatic send_bits(input logic [63:0] data, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, data[n-1-i]);
      rx = {rx[62:0], cur_miso()};
    end
  endtask

  task automatic end_frame();
    drive(1'b1, 1'b0);
  endtask

  task automatic frame(input logic [1:0] op, input logic [63:0] data, input int n,
                       output logic [63:0] rx);
    start_frame(op);
    send_bits(data, n, rx);
    end_frame();
  endtask

  initial begin
    logic [63:0] rx;
    tests   = 0;
    fails   = 0;
    cur_sel = 0;

    vecs[0] = '{op: 2'b00, data: 64'h3C,     nbits: 8,  exp_rx: 64'h0,    exp_wr: 8'h3C, exp_rd: 8'h00};
    vecs[1] = '{op: 2'b01, data: 64'hA5,     nbits: 8,  exp_rx: 64'h0,    exp_wr: 8'h3D, exp_rd: 8'h00};
    vecs[2] = '{op: 2'b01, data: 64'h5A,     nbits: 8,  exp_rx: 64'h0,    exp_wr: 8'h3E, exp_rd: 8'h00};
    vecs[3] = '{op: 2'b10, data: 64'h3C,     nbits: 8,  exp_rx: 64'h0,    exp_wr: 8'h3E, exp_rd: 8'h3C};
    vecs[4] = '{op: 2'b11, data: 64'h0,      nbits: 16, exp_rx: 64'hA55A, exp_wr: 8'h3E, exp_rd: 8'h3E};
    vecs[5] = '{op: 2'b00, data: 64'hFE,     nbits: 8,  exp_rx: 64'h0,    exp_wr: 8'hFE, exp_rd: 8'h3E};
    vecs[6] = '{op: 2'b01, data: 64'h112233, nbits: 24, exp_rx: 64'h0,    exp_wr: 8'h01, exp_rd: 8'h3E};
    vecs[7] = '{op: 2'b10, data: 64'hFF,     nbits: 8,  exp_rx: 64'h0,    exp_wr: 8'h01, exp_rd: 8'hFF};
    vecs[8] = '{op: 2'b11, data: 64'h0,      nbits: 16, exp_rx: 64'h2233, exp_wr: 8'h01, exp_rd: 8'h01};

    // Reset
    rst_n  = 1'b0;
    ss_a   = 1'b1;
    ss_b   = 1'b1;
    mosi_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset miso_a", 64'(miso_a), 64'h0);
    check("reset wr_a", 64'(dut_a.wr_addr_q), 64'h0);
    check("reset rd_a", 64'(dut_a.rd_addr_q), 64'h0);
    check("reset miso_b", 64'(miso_b), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of complete frames on the 8/8 instance
    for (int i = 0; i < 9; i++) begin
      frame(vecs[i].op, vecs[i].data, vecs[i].nbits, rx);
      if (vecs[i].op == 2'b11)
        check($sformatf("vec%0d rx", i), rx, vecs[i].exp_rx);
      check($sformatf("vec%0d wr_addr", i), 64'(dut_a.wr_addr_q), 64'(vecs[i].exp_wr));
      check($sformatf("vec%0d rd_addr", i), 64'(dut_a.rd_addr_q), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d miso idle", i), 64'(miso_a), 64'h0);
    end
    check("mem[3C]", 64'(dut_a.mem[8'h3C]), 64'hA5);
    check("mem[3D]", 64'(dut_a.mem[8'h3D]), 64'h5A);
    check("wrap mem[FE]", 64'(dut_a.mem[8'hFE]), 64'h11);
    check("wrap mem[FF]", 64'(dut_a.mem[8'hFF]), 64'h22);
    check("wrap mem[00]", 64'(dut_a.mem[8'h00]), 64'h33);

    // Write commit timing: nothing lands until the 8th payload bit
    frame(2'b00, 64'h40, 8, rx);
    start_frame(2'b01);
    send_bits(64'h61, 7, rx);            // top 7 bits of 0xC3
    check("partial word wr_addr", 64'(dut_a.wr_addr_q), 64'h40);
    send_bits(64'h1, 1, rx);             // LSB
    check("commit mem[40]", 64'(dut_a.mem[8'h40]), 64'hC3);
    check("commit wr_addr", 64'(dut_a.wr_addr_q), 64'h41);
    end_frame();

    // Aborts: after 5 bits, and with SS_n rising on the last-bit edge
    frame(2'b00, 64'h80, 8, rx);
    frame(2'b01, 64'h77, 8, rx);
    frame(2'b00, 64'h80, 8, rx);
    start_frame(2'b01);
    send_bits(64'h1F, 5, rx);
    end_frame();
    check("abort5 mem[80]", 64'(dut_a.mem[8'h80]), 64'h77);
    check("abort5 wr_addr", 64'(dut_a.wr_addr_q), 64'h80);
    check("abort5 miso", 64'(miso_a), 64'h0);
    start_frame(2'b01);
    send_bits(64'h7F, 7, rx);
    drive(1'b1, 1'b1);
    check("abort_last mem[80]", 64'(dut_a.mem[8'h80]), 64'h77);
    check("abort_last wr_addr", 64'(dut_a.wr_addr_q), 64'h80);
    frame(2'b10, 64'h3D, 8, rx);
    check("post-abort rd_addr", 64'(dut_a.rd_addr_q), 64'h3D);
    start_frame(2'b11);
    check("read miso before payload", 64'(miso_a), 64'h0);
    send_bits(64'h0, 8, rx);
    check("read 3D rx", rx, 64'h5A);
    check("read 3D rd_addr", 64'(dut_a.rd_addr_q), 64'h3E);
    end_frame();
    check("read end miso", 64'(miso_a), 64'h0);

    // Reset in the middle of a WRITE payload
    frame(2'b00, 64'h80, 8, rx);
    start_frame(2'b01);
    send_bits(64'hF, 4, rx);
    rst_n = 1'b0;
    drive(1'b0, 1'b1);
    check("midrst miso", 64'(miso_a), 64'h0);
    check("midrst wr_addr", 64'(dut_a.wr_addr_q), 64'h0);
    check("midrst rd_addr", 64'(dut_a.rd_addr_q), 64'h0);
    rst_n = 1'b1;
    end_frame();
    check("midrst mem[80]", 64'(dut_a.mem[8'h80]), 64'h77);
    frame(2'b10, 64'h3C, 8, rx);
    frame(2'b11, 64'h0, 8, rx);
    check("after reset read rx", rx, 64'hA5);
    check("after reset rd_addr", 64'(dut_a.rd_addr_q), 64'h3D);

    // Wide instance: 10-bit address, 16-bit words, wrap at 0x3FF
    cur_sel = 1;
    end_frame();
    frame(2'b00, 64'h3FF, 10, rx);
    check("b wr_addr 3FF", 64'(dut_b.wr_addr_q), 64'h3FF);
    frame(2'b01, 64'hBEEF1234, 32, rx);
    check("b mem[3FF]", 64'(dut_b.mem[10'h3FF]), 64'hBEEF);
    check("b mem[000]", 64'(dut_b.mem[10'h000]), 64'h1234);
    check("b wr_addr wrap", 64'(dut_b.wr_addr_q), 64'h001);
    frame(2'b10, 64'h3FF, 10, rx);
    check("b rd_addr 3FF", 64'(dut_b.rd_addr_q), 64'h3FF);
    frame(2'b11, 64'h0, 32, rx);
    check("b burst rx", rx, 64'hBEEF1234);
    check("b rd_addr wrap", 64'(dut_b.rd_addr_q), 64'h001);
    check("b miso idle", 64'(miso_b), 64'h0);
    check("a miso quiet", 64'(miso_a), 64'h0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
